// File: rtl/rca_bist.sv
// rca_bist: built-in self test that drives vectors into an external ripple-carry adder and checks its sums
module rca_bist #(
  parameter int DWIDTH = 32,
  parameter int SETTLE_CYC = 2,
  parameter logic [DWIDTH-1:0] SEED = DWIDTH'(1),
  parameter logic [DWIDTH-1:0] TAPS = DWIDTH'(32'h80200003)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_vec,
  output logic [DWIDTH-1:0] rca_a,
  output logic [DWIDTH-1:0] rca_b,
  output logic              rca_cin,
  input  logic [DWIDTH-1:0] rca_res,
  input  logic              rca_cout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [15:0]       first_err_idx,
  output logic [15:0]       vec_cnt
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  localparam logic [DWIDTH-1:0] ALT = DWIDTH'({DWIDTH{2'b01}});
  state_t state, state_next;
  logic [15:0] num, scnt, vec_next, err_next;
  logic [DWIDTH-1:0] lfsr, lfsr_step;
  logic [DWIDTH:0] sum;
  logic mismatch, settled, accept;
  assign accept = start && (state == IDLE || state == DONE);
  assign busy = state == DRIVE || state == SETTLE || state == CHECK;
  assign done = state == DONE;
  // reference sum, error bookkeeping and next-state selection
  always_comb begin
    sum = {1'b0, rca_a} + {1'b0, rca_b} + {{DWIDTH{1'b0}}, rca_cin};
    mismatch = {rca_cout, rca_res} != sum;
    vec_next = vec_cnt + 16'd1;
    err_next = (mismatch && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    settled = scnt == 16'(SETTLE_CYC - 1);
    lfsr_step = {lfsr[DWIDTH-2:0], ^(lfsr & TAPS)};
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? (num_vec == 16'd0 ? DONE : DRIVE) : state;
      DRIVE:      state_next = SETTLE;
      SETTLE:     state_next = settled ? CHECK : SETTLE;
      CHECK:      state_next = vec_next == num ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end
  // state register; reset aborts any run
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  // operand drive, lfsr, settle timer and result counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num <= '0;
      scnt <= '0;
      lfsr <= SEED;
      rca_a <= '0;
      rca_b <= '0;
      rca_cin <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
      first_err_idx <= '0;
      vec_cnt <= '0;
    end else begin
      if (accept) begin
        num <= num_vec;
        lfsr <= SEED;
        err_cnt <= '0;
        first_err_idx <= '0;
        vec_cnt <= '0;
        pass <= num_vec == 16'd0;
      end
      if (state == DRIVE) begin
        scnt <= '0;
        if (vec_cnt == 16'd0) begin
          rca_a <= '0;
          rca_b <= '0;
          rca_cin <= 1'b0;
        end else if (vec_cnt == 16'd1) begin
          rca_a <= '1;
          rca_b <= '0;
          rca_cin <= 1'b1;
        end else if (vec_cnt == 16'd2) begin
          rca_a <= '1;
          rca_b <= '1;
          rca_cin <= 1'b1;
        end else if (vec_cnt == 16'd3) begin
          rca_a <= ALT;
          rca_b <= ~ALT;
          rca_cin <= 1'b0;
        end else begin
          rca_a <= lfsr;
          rca_b <= ~{lfsr[DWIDTH-2:0], lfsr[DWIDTH-1]};
          rca_cin <= lfsr[0] ^ lfsr[DWIDTH-1];
          lfsr <= lfsr_step;
        end
      end
      if (state == SETTLE) scnt <= scnt + 16'd1;
      if (state == CHECK) begin
        vec_cnt <= vec_next;
        err_cnt <= err_next;
        if (mismatch && err_cnt == 16'd0) first_err_idx <= vec_cnt;
        if (vec_next == num) pass <= err_next == 16'd0;
      end
    end
  end
endmodule

// File: doc/rca_bist.md
RCA_BIST -- requirements
Module: rca_bist

Interface
REQ-001 Parameter DWIDTH, 32: operand/result width, >= 4.
REQ-002 Parameter SETTLE_CYC, 2: cycles allowed for the adder to settle, >= 1.
REQ-003 Parameter SEED, 1: LFSR reload value, non-zero.
REQ-004 Parameter TAPS, 32'h80200003: Fibonacci LFSR feedback mask, DWIDTH bits.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 start  in  1  single-cycle run request.
REQ-009 num_vec  in  16  number of vectors per run, sampled on accepted start.
REQ-010 rca_a  out  DWIDTH  operand A to the adder under test.
REQ-011 rca_b  out  DWIDTH  operand B to the adder under test.
REQ-012 rca_cin  out  1  carry-in to the adder under test.
REQ-013 rca_res  in  DWIDTH  sum from the adder under test.
REQ-014 rca_cout  in  1  carry-out from the adder under test.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  run finished; held until the next accepted start.
REQ-017 pass  out  1  valid when done; 1 when err_cnt is 0.
REQ-018 err_cnt  out  16  mismatch count, saturates at 16'hFFFF.
REQ-019 first_err_idx  out  16  index of the first mismatching vector.
REQ-020 vec_cnt  out  16  vectors checked in the current or last run.

Function
REQ-021 The FSM SHALL have five states: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-022 In IDLE or DONE, start=1 SHALL latch num_vec and clear err_cnt, first_err_idx, vec_cnt, pass and done.
REQ-023 On the same start, the LFSR SHALL reload SEED and the FSM SHALL go to DRIVE, or to DONE if num_vec=0.
REQ-024 start SHALL be ignored in DRIVE, SETTLE and CHECK.
REQ-025 DRIVE SHALL register the vector for index vec_cnt onto rca_a/rca_b/rca_cin, then move to SETTLE; outputs hold until the next DRIVE.
REQ-026 Vectors 0-3 SHALL be fixed: (0,0,0), (all-ones,0,1), (all-ones,all-ones,1), (0x55..55,0xAA..AA,0).
REQ-027 Vectors >= 4 SHALL use a=lfsr, b=~{lfsr[DWIDTH-2:0],lfsr[DWIDTH-1]} and cin=lfsr[0]^lfsr[DWIDTH-1].
REQ-028 The LFSR SHALL advance one step after each such vector is driven.
REQ-029 SETTLE SHALL last exactly SETTLE_CYC cycles, then move to CHECK.
REQ-030 CHECK SHALL compare {rca_cout,rca_res} with the DWIDTH+1-bit sum rca_a+rca_b+rca_cin in one cycle.
REQ-031 On mismatch, err_cnt SHALL increment (saturating), and first_err_idx SHALL capture vec_cnt only when err_cnt was 0.
REQ-032 CHECK SHALL increment vec_cnt, then go to DONE when the new vec_cnt equals num_vec, else to DRIVE.
REQ-033 Per-vector latency SHALL be SETTLE_CYC+2 cycles.
REQ-034 busy SHALL be 1 exactly in DRIVE, SETTLE and CHECK.
REQ-035 done SHALL be 1 in DONE, and pass SHALL be registered as (err_cnt==0) on entry to DONE.
REQ-036 vec_cnt SHALL wrap 16'hFFFF to 0 only if num_vec=0 is impossible at that point; num_vec=16'hFFFF SHALL run 65535 vectors.

Reset
REQ-037 rst_n=0 at a clock edge SHALL force IDLE, set every output to 0, load the LFSR with SEED and abort any run, including mid-SETTLE.
REQ-038 start coincident with rst_n=0 SHALL be ignored.

Verification (DWIDTH=8, SETTLE_CYC=2, correct adder model unless stated)
REQ-039 start, num_vec=4 -> busy for 16 cycles, done=1, pass=1, err_cnt=0, vec_cnt=4.
REQ-040 Adder with rca_res[0] stuck-at-0, num_vec=4 -> err_cnt=2, first_err_idx=2, pass=0.
REQ-041 Adder with rca_cout stuck-at-0, num_vec=2 -> vector 1 expects 0x100, so err_cnt=1, first_err_idx=1.
REQ-042 start with num_vec=0 -> DONE on the next cycle, pass=1, vec_cnt=0, rca_a/rca_b/rca_cin unchanged (0).
REQ-043 rst_n low for one cycle during SETTLE of vector 2 -> all outputs 0; a new start re-drives vector 0 = (0,0,0).
REQ-044 start pulses while busy -> ignored (vec_cnt not cleared); start in DONE -> counters cleared, identical LFSR sequence is repeated.
